// File: rtl/quad_encoder_emulator.sv
// quad_encoder_emulator: quadrature A/B(/Z) generator driven by a step handshake with programmable dwell.
// Define QUAD_ENC_EMU_INDEX_EN to enable the revolution counter and index output o_z.
module quad_encoder_emulator #(
  parameter int POS_W          = 32,
  parameter int PER_W          = 16,
  parameter int COUNTS_PER_REV = 2048
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_step_valid,
  output logic             o_step_ready,
  input  logic             i_step_dir,
  input  logic             i_polarity,
  input  logic [PER_W-1:0] i_min_period,
  output logic             o_a,
  output logic             o_b,
  output logic             o_z,
  output logic [POS_W-1:0] o_position,
  output logic             o_busy
);
  typedef enum logic {IDLE, DWELL} state_t;
  state_t state_q, state_d;
  logic [1:0] p_q, p_d, ab_q, ab_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [PER_W-1:0] cnt_q, cnt_d, per;
  logic acc, eff;
  if (COUNTS_PER_REV < 4) begin : g_bad_cpr
    $error("COUNTS_PER_REV must be >= 4");
  end
  assign eff = i_step_dir ^ i_polarity;
  assign acc = i_step_valid && (state_q == IDLE);
  assign per = (i_min_period == '0) ? PER_W'(1) : i_min_period;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    pos_d   = pos_q;
    if (state_q == DWELL) begin
      if (cnt_q == '0) state_d = IDLE;
      else cnt_d = cnt_q - PER_W'(1);
    end else if (acc) begin
      p_d   = eff ? p_q - 2'd1 : p_q + 2'd1;
      pos_d = eff ? pos_q - POS_W'(1) : pos_q + POS_W'(1);
      if (per > PER_W'(1)) begin
        state_d = DWELL;
        cnt_d   = per - PER_W'(2);
      end
    end
  end
  // Gray-code A/B is registered from the next phase so each output is a flop.
  assign ab_d = {p_d[1] ^ p_d[0], p_d[1]};
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      ab_q    <= '0;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      ab_q    <= ab_d;
      pos_q   <= pos_d;
    end
  end
`ifdef QUAD_ENC_EMU_INDEX_EN
  localparam int R_W = $clog2(COUNTS_PER_REV);
  localparam logic [R_W-1:0] R_MAX = R_W'(COUNTS_PER_REV - 1);
  logic [R_W-1:0] r_q, r_d;
  logic z_q;
  always_comb begin
    r_d = r_q;
    if (acc) r_d = eff ? ((r_q == '0) ? R_MAX : r_q - R_W'(1))
                       : ((r_q == R_MAX) ? '0 : r_q + R_W'(1));
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= '0;
      z_q <= 1'b1;
    end else begin
      r_q <= r_d;
      z_q <= (r_d == '0);
    end
  end
  assign o_z = z_q;
`else
  assign o_z = 1'b0;
`endif
  assign o_a          = ab_q[1];
  assign o_b          = ab_q[0];
  assign o_position   = pos_q;
  assign o_step_ready = (state_q == IDLE);
  assign o_busy       = (state_q == DWELL);
endmodule

// File: tb/tb_quad_encoder_emulator.sv
// tb_quad_encoder_emulator: table-driven and directed checks of the quadrature encoder emulator (CPR=4).
module tb_quad_encoder_emulator;
  localparam int POS_W = 32;
  localparam int PER_W = 16;
  localparam int CPR   = 4;
`ifdef QUAD_ENC_EMU_INDEX_EN
  localparam logic ZEN = 1'b1;
`else
  localparam logic ZEN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, v, d, pol, rdy, a, b, z, busy;
  logic [PER_W-1:0] per;
  logic [POS_W-1:0] pos;
  int compared = 0;
  int mismatched = 0;
  quad_encoder_emulator #(.POS_W(POS_W), .PER_W(PER_W), .COUNTS_PER_REV(CPR)) dut (
    .i_clk(clk), .i_rst(rst), .i_step_valid(v), .o_step_ready(rdy), .i_step_dir(d),
    .i_polarity(pol), .i_min_period(per), .o_a(a), .o_b(b), .o_z(z),
    .o_position(pos), .o_busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic v, d, pol;
    logic [PER_W-1:0] per;
    logic [1:0] ab;
    logic [POS_W-1:0] pos;
    logic rdy, busy, z;
  } vec_t;
  vec_t vecs [12];
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, want %0h", n, act, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; v = 1'b0; d = 1'b0; pol = 1'b0; per = 16'd1;
    @(negedge clk);
    rst = 1'b0;
    chk("reset_ab", {a, b}, 2'b00);
    chk("reset_pos", pos, 0);
    chk("reset_ready", rdy, 1);
    chk("reset_busy", busy, 0);
    chk("reset_z", z, ZEN);
  endtask
  task automatic step(input logic vv, input logic dd, input logic pp, input logic [PER_W-1:0] pr);
    v = vv; d = dd; pol = pp; per = pr;
    @(posedge clk);
    #1;
  endtask
  logic [1:0] rev_ab [3];
  initial begin
    rst = 1'b1; v = 1'b0; d = 1'b0; pol = 1'b0; per = 16'd1;
    // fields: v d pol per | ab pos rdy busy z(index build)
    vecs[0]  = '{1, 0, 0, 16'd1,  2'b10, 32'd1, 1, 0, 0};
    vecs[1]  = '{1, 0, 0, 16'd1,  2'b11, 32'd2, 1, 0, 0};
    vecs[2]  = '{1, 0, 0, 16'd1,  2'b01, 32'd3, 1, 0, 0};
    vecs[3]  = '{1, 0, 0, 16'd1,  2'b00, 32'd4, 1, 0, 1};
    vecs[4]  = '{1, 1, 0, 16'd0,  2'b01, 32'd3, 1, 0, 0};
    vecs[5]  = '{1, 0, 1, 16'd1,  2'b11, 32'd2, 1, 0, 0};
    vecs[6]  = '{1, 1, 1, 16'd1,  2'b01, 32'd3, 1, 0, 0};
    vecs[7]  = '{0, 0, 0, 16'd1,  2'b01, 32'd3, 1, 0, 0};
    vecs[8]  = '{1, 0, 0, 16'd3,  2'b00, 32'd4, 0, 1, 1};
    vecs[9]  = '{1, 1, 0, 16'd10, 2'b00, 32'd4, 0, 1, 1};
    vecs[10] = '{1, 1, 0, 16'd10, 2'b00, 32'd4, 1, 0, 1};
    vecs[11] = '{1, 1, 0, 16'd1,  2'b01, 32'd3, 1, 0, 0};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].v, vecs[i].d, vecs[i].pol, vecs[i].per);
      chk($sformatf("vec%0d_ab", i), {a, b}, vecs[i].ab);
      chk($sformatf("vec%0d_pos", i), pos, vecs[i].pos);
      chk($sformatf("vec%0d_ready", i), rdy, vecs[i].rdy);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
      chk($sformatf("vec%0d_z", i), z, vecs[i].z & ZEN);
      @(negedge clk);
    end
    // Period 5 under continuous valid: one accept every 5 cycles.
    do_reset();
    for (int k = 1; k <= 15; k++) begin
      step(1, 0, 0, 16'd5);
      chk($sformatf("p5_pos%0d", k), pos, (k - 1) / 5 + 1);
      chk($sformatf("p5_busy%0d", k), busy, ((k - 1) % 5) != 4);
      @(negedge clk);
    end
    // Dwell of P=10 after the period input changed mid-dwell above.
    do_reset();
    step(1, 0, 0, 16'd10);
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      step(1, 0, 0, 16'd1);
      chk($sformatf("p10_pos%0d", k), pos, 1);
    end
    @(negedge clk);
    step(1, 0, 0, 16'd1);
    chk("p10_next_accept", pos, 2);
    // Reverse direction either via dir or via polarity.
    rev_ab[0] = 2'b01; rev_ab[1] = 2'b11; rev_ab[2] = 2'b10;
    for (int m = 0; m < 2; m++) begin
      do_reset();
      for (int k = 0; k < 3; k++) begin
        step(1, m == 0, m == 1, 16'd1);
        chk($sformatf("rev%0d_ab%0d", m, k), {a, b}, rev_ab[k]);
        @(negedge clk);
      end
      chk($sformatf("rev%0d_pos", m), pos, 32'hFFFF_FFFD);
    end
    // Asynchronous reset two cycles into a P=6 dwell.
    do_reset();
    step(1, 0, 0, 16'd6);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_ab", {a, b}, 2'b00);
    chk("arst_pos", pos, 0);
    chk("arst_ready", rdy, 1);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("arst_reaccept_pos", pos, 1);
    chk("arst_reaccept_ab", {a, b}, 2'b10);
    chk("arst_reaccept_busy", busy, 1);
    // Index across one forward revolution then one reverse step.
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      step(1, 0, 0, 16'd1);
      chk($sformatf("idx_fwd%0d", k), z, (k == 4) & ZEN);
      @(negedge clk);
    end
    step(1, 1, 0, 16'd1);
    chk("idx_rev_z", z, 0);
    chk("idx_rev_ab", {a, b}, 2'b01);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/quad_encoder_emulator.md
Name: quad_encoder_emulator

Overview:
Generates quadrature A/B signals, plus an optional index, from a stream of step requests. It is the transmit-side counterpart of the encoder reader in the motor path. It is used as a hardware-in-the-loop encoder source and as a stimulus generator for motor-control verification. Each accepted request moves the quadrature phase one count forward or backward, then holds for a programmable minimum dwell.

Parameters:
POS_W, 32, width of signed position counter o_position
PER_W, 16, width of dwell period input i_min_period
COUNTS_PER_REV, 2048, quadrature counts per revolution; used only by index feature; must be >= 4

Ports:
i_clk  input  1  master clock
i_rst  input  1  asynchronous active-high reset
i_step_valid  input  1  step request valid
o_step_ready  output  1  block can accept a step this cycle
i_step_dir  input  1  step direction: 0 = forward, 1 = reverse
i_polarity  input  1  output polarity; 1 swaps meaning of i_step_dir
i_min_period  input  PER_W  minimum cycles between accepted steps; 0 treated as 1
o_a  output  1  quadrature channel A
o_b  output  1  quadrature channel B
o_z  output  1  index channel
o_position  output  POS_W  signed count of accepted steps
o_busy  output  1  dwell in progress

Behaviour:
- One clock, i_clk. Reset i_rst is asynchronous and active-high.
- Reset values: o_a=0, o_b=0, o_z per Optional Feature, o_position=0, state=IDLE, o_step_ready=1, o_busy=0, dwell counter=0.
- Quadrature phase p is a 2-bit register. Encoding {o_a,o_b}: p0=00, p1=10, p2=11, p3=01. Outputs are registered directly from p, with no glitches.
- Effective direction: eff = i_step_dir XOR i_polarity. eff=0 gives p+1 mod 4; eff=1 gives p-1 mod 4. Exactly one of A/B toggles per step.
- Handshake: a step is accepted on a rising edge where i_step_valid && o_step_ready. i_step_dir is sampled on that edge. The request is not buffered. The source holds valid until it sees ready.
- o_step_ready = (state==IDLE), decoded from registered state only, with no combinational path from i_step_valid.
- On accept, on the same edge:
  - p updates, so new A/B are visible in the following cycle (latency 1).
  - o_position changes by +1 (eff=0) or -1 (eff=1).
  - Let P = max(i_min_period,1). If P==1, stay in IDLE, so back-to-back steps every cycle are allowed. If P>=2, go to DWELL and load counter with P-2.
- DWELL state:
  - o_busy=1 and o_step_ready=0.
  - If counter==0, go to IDLE on the next edge; otherwise decrement.
  - Result: accepted steps are spaced exactly P cycles apart under continuous valid.
- i_min_period is sampled only at accept. Changes during DWELL do not affect the current dwell.
- o_position wraps two's complement: +1 at max positive gives max negative, and the reverse for -1.
- Direction reversal between consecutive steps is legal. A/B return to the previous code.
- Asynchronous reset mid-DWELL aborts the dwell. All state returns to reset values immediately, and a pending request is dropped.

Optional Feature:
Macro QUAD_ENC_EMU_INDEX_EN.
- Defined:
  - An internal revolution counter r (0..COUNTS_PER_REV-1) tracks accepted steps. It increments with wrap CPR-1 to 0 when eff=0, and decrements with wrap 0 to CPR-1 when eff=1.
  - o_z is registered, equal to (r==0). It is 1 after reset and stays high for the whole period the phase sits at r==0.
- Not defined: r is absent and o_z is tied 0.
- All other behaviour is identical in both builds.

Test Plan:
1. Reset with i_min_period=1 and valid held high, dir=0, pol=0 for 8 cycles -> A/B sequence 10,11,01,00,10,11,01,00 on consecutive cycles; o_position=8; ready never drops.
2. i_min_period=5, valid held, dir=0 -> accepts exactly every 5 cycles; o_busy high 4 cycles after each accept; A/B toggle once per 5 cycles.
3. dir=1, pol=0, 3 steps from reset -> A/B = 01,11,10; o_position = -3 (0xFFFFFFFD). Repeat with dir=0, pol=1 -> identical outputs.
4. i_min_period=0 -> behaves as 1; then change to 10 while in DWELL after a P=3 accept -> current dwell still 3 cycles; next dwell 10.
5. Assert i_rst two cycles into a P=6 dwell -> A/B=00, o_position=0, ready=1 immediately; the held request is accepted on the first edge after release.
6. QUAD_ENC_EMU_INDEX_EN, COUNTS_PER_REV=4 -> o_z=1 at reset; 0 after step 1; 1 again after 4 forward steps; one reverse step from r=0 gives r=3 and o_z=0.
